// File: rtl/bcd7seg_pkg.sv
// Shared definitions for the BCD 7-segment display controller.
//   SEG_W          width of one 7-segment pattern (bit0=a .. bit6=g, active-low)
//   SEG_0..SEG_9   digit patterns
//   SEG_BLANK      all segments off
//   SEG_DASH       only segment g lit, shown on overflow
//   SCR_W          double-dabble scratch width: four BCD nibbles plus one spare
//   state_t        controller FSM states
//   dabble_step    one add-3-then-shift iteration of the scratch register
package bcd7seg_pkg;

    localparam int SEG_W = 7;
    localparam int SCR_W = 20;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Correct every nibble that would exceed 9 after doubling, then shift in lsb.
    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] scr,
                                                     input logic            lsb);
        logic [SCR_W-1:0] adj;
        adj = scr;
        for (int i = 0; i < SCR_W/4; i++) begin
            if (scr[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
            end
        end
        return (adj << 1) | SCR_W'(lsb);
    endfunction

endpackage

// File: rtl/seg7_digit_encode.sv
// Combinational BCD digit to 7-segment pattern encoder (active-low).
//   digit  in   4      BCD digit; codes 10..15 render blank
//   blank  in   1      force the display off
//   seg    out  SEG_W  pattern, bit0=a .. bit6=g
module seg7_digit_encode
    import bcd7seg_pkg::*;
(
    input  logic [3:0]       digit,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd7seg_display_ctrl.sv
// Binary to four-digit 7-segment display controller.
// A start request launches a BIN_W-cycle double-dabble conversion; the display
// registers load only on completion, so partial results never reach the HEX outputs.
//   clk           in   1      system clock
//   rst_n         in   1      synchronous active-low reset
//   start         in   1      conversion request, bin_in sampled on the same edge
//   bin_in        in   BIN_W  binary value
//   busy          out  1      conversion in progress
//   done          out  1      one-cycle pulse while new results are presented
//   overflow      out  1      last accepted value exceeded MAX_VAL
//   bcd_out       out  16     {thousands, hundreds, tens, units}
//   segment_1000  out  7      thousands display (active-low)
//   segment_100   out  7      hundreds display
//   segment_10    out  7      tens display
//   segment_1     out  7      units display
//
// state  | meaning
// IDLE   | waiting for start, outputs hold
// SHIFT  | one add-3/shift iteration per cycle, BIN_W cycles
// UPDATE | results presented, done pulse
module bcd7seg_display_ctrl
    import bcd7seg_pkg::*;
#(
    parameter int          BIN_W    = 14,
    parameter int unsigned MAX_VAL  = 9999,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      bcd_out,
    output logic [SEG_W-1:0] segment_1000,
    output logic [SEG_W-1:0] segment_100,
    output logic [SEG_W-1:0] segment_10,
    output logic [SEG_W-1:0] segment_1
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t           state, state_nx;
    logic [BIN_W-1:0] shift_reg, shift_nx;
    logic [SCR_W-1:0] scratch, scratch_nx, scratch_step;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ovf_pending, ovf_pending_nx;
    logic             load_out;

    logic [3:0]       dig_1000, dig_100, dig_10, dig_1;
    logic             blank_1000, blank_100, blank_10;
    logic [SEG_W-1:0] enc_1000, enc_100, enc_10, enc_1;

    // The encoders look at the result of the final iteration directly, so the
    // output registers can load on the same edge the FSM enters UPDATE.
    always_comb begin
        scratch_step = dabble_step(scratch, shift_reg[BIN_W-1]);
        dig_1000     = scratch_step[15:12];
        dig_100      = scratch_step[11:8];
        dig_10       = scratch_step[7:4];
        dig_1        = scratch_step[3:0];
        blank_1000   = BLANK_LZ && (dig_1000 == 4'd0);
        blank_100    = blank_1000 && (dig_100 == 4'd0);
        blank_10     = blank_100 && (dig_10 == 4'd0);
    end

    seg7_digit_encode u_enc_1000 (.digit(dig_1000), .blank(blank_1000), .seg(enc_1000));
    seg7_digit_encode u_enc_100  (.digit(dig_100),  .blank(blank_100),  .seg(enc_100));
    seg7_digit_encode u_enc_10   (.digit(dig_10),   .blank(blank_10),   .seg(enc_10));
    seg7_digit_encode u_enc_1    (.digit(dig_1),    .blank(1'b0),       .seg(enc_1));

    always_comb begin
        state_nx       = state;
        shift_nx       = shift_reg;
        scratch_nx     = scratch;
        cnt_nx         = cnt;
        ovf_pending_nx = ovf_pending;
        load_out       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx       = SHIFT;
                    shift_nx       = bin_in;
                    scratch_nx     = '0;
                    cnt_nx         = CNT_W'(BIN_W);
                    ovf_pending_nx = (32'(bin_in) > MAX_VAL);
                end
            end
            SHIFT: begin
                shift_nx   = shift_reg << 1;
                scratch_nx = scratch_step;
                cnt_nx     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = UPDATE;
                    load_out = 1'b1;
                end
            end
            UPDATE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            shift_reg   <= shift_nx;
            scratch     <= scratch_nx;
            cnt         <= cnt_nx;
            ovf_pending <= ovf_pending_nx;
            busy        <= (state_nx != IDLE);
            done        <= (state_nx == UPDATE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow     <= 1'b0;
            bcd_out      <= '0;
            segment_1000 <= SEG_BLANK;
            segment_100  <= SEG_BLANK;
            segment_10   <= SEG_BLANK;
            segment_1    <= SEG_BLANK;
        end else if (load_out) begin
            overflow <= ovf_pending;
            if (ovf_pending) begin
                bcd_out      <= '0;
                segment_1000 <= SEG_DASH;
                segment_100  <= SEG_DASH;
                segment_10   <= SEG_DASH;
                segment_1    <= SEG_DASH;
            end else begin
                bcd_out      <= scratch_step[15:0];
                segment_1000 <= enc_1000;
                segment_100  <= enc_100;
                segment_10   <= enc_10;
                segment_1    <= enc_1;
            end
        end
    end

endmodule

// File: tb/tb_bcd7seg_display_ctrl.sv
// Scoreboard bench: expected results are queued when a request is driven and
// compared when done pulses. A second instance with leading-zero blanking off
// receives the same stimulus.
module tb_bcd7seg_display_ctrl;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [27:0] seg;      // {1000, 100, 10, 1}
        logic [27:0] seg_nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;

    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [6:0]  segment_1000, segment_100, segment_10, segment_1;
    logic        nb_busy, nb_done, nb_overflow;
    logic [15:0] nb_bcd_out;
    logic [6:0]  nb_segment_1000, nb_segment_100, nb_segment_10, nb_segment_1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_done = 1'b0;

    logic [6:0] enc_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    bcd7seg_display_ctrl #(.BIN_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out),
        .segment_1000(segment_1000), .segment_100(segment_100),
        .segment_10(segment_10), .segment_1(segment_1)
    );

    bcd7seg_display_ctrl #(.BIN_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(nb_busy), .done(nb_done), .overflow(nb_overflow), .bcd_out(nb_bcd_out),
        .segment_1000(nb_segment_1000), .segment_100(nb_segment_100),
        .segment_10(nb_segment_10), .segment_1(nb_segment_1)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int d3, d2, d1, d0;
        logic [6:0] s3, s2, s1, s0;
        if (v > 9999) begin
            e.bcd    = 16'h0000;
            e.ovf    = 1'b1;
            e.seg    = {4{7'b0111111}};
            e.seg_nb = {4{7'b0111111}};
        end else begin
            d3 = v / 1000;
            d2 = (v / 100) % 10;
            d1 = (v / 10) % 10;
            d0 = v % 10;
            e.bcd    = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
            e.ovf    = 1'b0;
            s3 = (d3 == 0) ? 7'b1111111 : enc_tab[d3];
            s2 = (d3 == 0 && d2 == 0) ? 7'b1111111 : enc_tab[d2];
            s1 = (d3 == 0 && d2 == 0 && d1 == 0) ? 7'b1111111 : enc_tab[d1];
            s0 = enc_tab[d0];
            e.seg    = {s3, s2, s1, s0};
            e.seg_nb = {enc_tab[d3], enc_tab[d2], enc_tab[d1], enc_tab[d0]};
        end
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk_eq("done_width", 32'(prev_done), 32'd0);
            chk_eq("nb_done", 32'(nb_done), 32'd1);
            if (sb.size() == 0) begin
                chk_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk_eq("bcd_out",      32'(bcd_out),         32'(mon_e.bcd));
                chk_eq("overflow",     32'(overflow),        32'(mon_e.ovf));
                chk_eq("seg_1000",     32'(segment_1000),    32'(mon_e.seg[27:21]));
                chk_eq("seg_100",      32'(segment_100),     32'(mon_e.seg[20:14]));
                chk_eq("seg_10",       32'(segment_10),      32'(mon_e.seg[13:7]));
                chk_eq("seg_1",        32'(segment_1),       32'(mon_e.seg[6:0]));
                chk_eq("nb_bcd_out",   32'(nb_bcd_out),      32'(mon_e.bcd));
                chk_eq("nb_seg_1000",  32'(nb_segment_1000), 32'(mon_e.seg_nb[27:21]));
                chk_eq("nb_seg_100",   32'(nb_segment_100),  32'(mon_e.seg_nb[20:14]));
                chk_eq("nb_seg_10",    32'(nb_segment_10),   32'(mon_e.seg_nb[13:7]));
                chk_eq("nb_seg_1",     32'(nb_segment_1),    32'(mon_e.seg_nb[6:0]));
            end
        end
        prev_done = done;
    end

    // One conversion; optionally pokes a second start (ignored by the DUT) at poke_cyc.
    task automatic run_conv(input int v, input int poke_cyc, input int poke_val);
        int  lat;
        bit  seen;
        @(posedge clk);
        #1;
        chk_eq("busy_idle", 32'(busy), 32'd0);
        start  = 1'b1;
        bin_in = 14'(v);
        sb.push_back(model(v));
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 14'(v) ^ 14'h2AAA;
        lat    = 0;
        seen   = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk_eq("busy_run", 32'(busy), 32'd1);
            if (done) begin
                seen = 1'b1;
                chk_eq("busy_update", 32'(busy), 32'd1);
            end
            if (poke_cyc != 0 && lat == poke_cyc) begin
                start  = 1'b1;
                bin_in = 14'(poke_val);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk_eq("latency", 32'(lat), 32'd15);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_eq({tag, "_busy"},     32'(busy),         32'd0);
        chk_eq({tag, "_done"},     32'(done),         32'd0);
        chk_eq({tag, "_overflow"}, 32'(overflow),     32'd0);
        chk_eq({tag, "_bcd"},      32'(bcd_out),      32'd0);
        chk_eq({tag, "_seg_1000"}, 32'(segment_1000), 32'h7F);
        chk_eq({tag, "_seg_100"},  32'(segment_100),  32'h7F);
        chk_eq({tag, "_seg_10"},   32'(segment_10),   32'h7F);
        chk_eq({tag, "_seg_1"},    32'(segment_1),    32'h7F);
        chk_eq({tag, "_nb_seg_1"}, 32'(nb_segment_1), 32'h7F);
    endtask

    initial begin
        int step;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_conv(807, 0, 0);
        run_conv(9999, 0, 0);
        run_conv(10000, 0, 0);
        run_conv(16383, 0, 0);
        run_conv(0, 0, 0);
        run_conv(6025, 5, 7777);
        run_conv(7777, 0, 0);
        run_conv(1023, 0, 0);

        // Abort a conversion with reset; no done may follow.
        @(posedge clk);
        #1;
        start  = 1'b1;
        bin_in = 14'd777;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_reset_state("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_eq("abort_no_done", 32'(done), 32'd0);
        end
        run_conv(777, 0, 0);

        // Sweep: dense at the boundaries, strided elsewhere.
        for (int v = 0; v < 16384; v += step) begin
            run_conv(v, 0, 0);
            step = (v < 20 || (v >= 9985 && v < 10015) || v >= 16370) ? 1 : 13;
        end

        repeat (5) @(negedge clk);
        chk_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
